// File: rtl/pico_bus_fabric_pkg.sv
// rtl/pico_bus_fabric_pkg.sv - shared widths, FSM state type and index-width helper
package pico_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pico_bus_fabric_if.sv
// rtl/pico_bus_fabric_if.sv - master-side and slave-side bus signals with fabric-facing modports
interface pico_bus_fabric_if
   import pico_bus_pkg::*;
#(
   parameter int NSLV = 4
) ();

   logic                   m_valid;
   logic                   m_instr;
   logic [ADDR_W-1:0]      m_addr;
   logic [DATA_W-1:0]      m_wdata;
   logic [STRB_W-1:0]      m_wstrb;
   logic                   m_ready;
   logic [DATA_W-1:0]      m_rdata;
   logic                   err_irq;
   logic [ADDR_W-1:0]      err_addr;

   logic [NSLV-1:0]        s_sel;
   logic [ADDR_W-1:0]      s_addr;
   logic [DATA_W-1:0]      s_wdata;
   logic [STRB_W-1:0]      s_wstrb;
   logic [NSLV-1:0]        s_ready;
   logic [NSLV*DATA_W-1:0] s_rdata;

   // Fabric view of the requesting master.
   modport master (
      input  m_valid, m_instr, m_addr, m_wdata, m_wstrb,
      output m_ready, m_rdata, err_irq, err_addr
   );

   // Fabric view of the slave regions.
   modport slave (
      output s_sel, s_addr, s_wdata, s_wstrb,
      input  s_ready, s_rdata
   );

endinterface

// File: rtl/pico_bus_fabric_addr_decode.sv
// rtl/pico_bus_fabric_addr_decode.sv - base/mask region match, lowest index wins
module pico_addr_decode
   import pico_bus_pkg::*;
#(
   parameter int NSLV  = 4,
   parameter int IDX_W = idx_width(NSLV)
) (
   input  logic [ADDR_W-1:0]      addr_i,
   input  logic [NSLV*ADDR_W-1:0] bases_i,
   input  logic [NSLV*ADDR_W-1:0] masks_i,
   output logic                   hit_o,
   output logic [IDX_W-1:0]       index_o
);

   // Scan from the top down so the lowest matching index overwrites the rest.
   always_comb begin
      hit_o   = 1'b0;
      index_o = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((masks_i[i*ADDR_W +: ADDR_W] != '0) &&
             ((addr_i & masks_i[i*ADDR_W +: ADDR_W]) ==
              (bases_i[i*ADDR_W +: ADDR_W] & masks_i[i*ADDR_W +: ADDR_W]))) begin
            hit_o   = 1'b1;
            index_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/pico_bus_fabric.sv
// rtl/pico_bus_fabric.sv - single-master to NSLV-slave fabric; BUS_TIMEOUT_EN adds a slave-wait timeout
module pico_bus_fabric
   import pico_bus_pkg::*;
#(
   parameter int                     NSLV        = 4,
   parameter logic [NSLV*ADDR_W-1:0] SLV_BASE    = {32'h0010_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000},
   parameter logic [NSLV*ADDR_W-1:0] SLV_MASK    = {32'hFFFF_FFF0, 32'hFFF0_0000, 32'hFFFF_FC00, 32'h0000_0000},
   parameter int                     TIMEOUT_CYC = 255,
   parameter logic [DATA_W-1:0]      ERR_RDATA   = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   pico_bus_fabric_if.master  mst_if,
   pico_bus_fabric_if.slave   slv_if
);

   localparam int IDX_W = idx_width(NSLV);

   state_e              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic [NSLV-1:0]     sel_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic                m_ready_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_irq_q;
   logic [ADDR_W-1:0]   err_addr_q;
   logic                dec_hit;
   logic [IDX_W-1:0]    dec_idx;

`ifdef BUS_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0]         cnt_q;
`endif

   pico_addr_decode #(
      .NSLV  (NSLV),
      .IDX_W (IDX_W)
   ) u_decode (
      .addr_i  (mst_if.m_addr),
      .bases_i (SLV_BASE),
      .masks_i (SLV_MASK),
      .hit_o   (dec_hit),
      .index_o (dec_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         sel_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         m_ready_q  <= 1'b0;
         rdata_q    <= '0;
         err_irq_q  <= 1'b0;
         err_addr_q <= '0;
`ifdef BUS_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         m_ready_q <= 1'b0;
         err_irq_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (mst_if.m_valid) begin
                  if (dec_hit) begin
                     addr_q         <= mst_if.m_addr;
                     wdata_q        <= mst_if.m_wdata;
                     wstrb_q        <= mst_if.m_wstrb;
                     idx_q          <= dec_idx;
                     sel_q          <= '0;
                     sel_q[dec_idx] <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                     cnt_q          <= '0;
`endif
                     state_q        <= ST_ACCESS;
                  end else begin
                     // Unmapped address: answer straight away, nothing reaches a slave.
                     rdata_q    <= ERR_RDATA;
                     err_addr_q <= mst_if.m_addr;
                     err_irq_q  <= 1'b1;
                     m_ready_q  <= 1'b1;
                     state_q    <= ST_RESP;
                  end
               end
            end
            ST_ACCESS: begin
               if (slv_if.s_ready[idx_q]) begin
                  rdata_q   <= slv_if.s_rdata[{idx_q, 5'd0} +: DATA_W];
                  sel_q     <= '0;
                  m_ready_q <= 1'b1;
                  state_q   <= ST_RESP;
               end
`ifdef BUS_TIMEOUT_EN
               else if (cnt_q == TMO_LAST) begin
                  rdata_q    <= ERR_RDATA;
                  err_addr_q <= addr_q;
                  err_irq_q  <= 1'b1;
                  sel_q      <= '0;
                  m_ready_q  <= 1'b1;
                  state_q    <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
`endif
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mst_if.m_ready  = m_ready_q;
   assign mst_if.m_rdata  = rdata_q;
   assign mst_if.err_irq  = err_irq_q;
   assign mst_if.err_addr = err_addr_q;
   assign slv_if.s_sel    = sel_q;
   assign slv_if.s_addr   = addr_q;
   assign slv_if.s_wdata  = wdata_q;
   assign slv_if.s_wstrb  = wstrb_q;

endmodule

// File: tb/tb_pico_bus_fabric.sv
// tb/tb_pico_bus_fabric.sv - directed checks of decode, latency, errors, waits and reset
module tb_pico_bus_fabric;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   int   cnt;
   logic seen;

   pico_bus_fabric_if #(.NSLV(4)) bus ();

   pico_bus_fabric #(
      .NSLV        (4),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .mst_if (bus),
      .slv_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic request(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
      bus.m_valid = 1'b1;
      bus.m_addr  = addr;
      bus.m_wdata = wdata;
      bus.m_wstrb = wstrb;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      bus.m_valid = 1'b0;
      bus.m_instr = 1'b0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.m_wstrb = '0;
      bus.s_ready = '0;
      bus.s_rdata = '0;
      step();
      step();
      chk("rst_s_sel",    32'(bus.s_sel),   32'h0);
      chk("rst_m_ready",  32'(bus.m_ready), 32'h0);
      chk("rst_err_irq",  32'(bus.err_irq), 32'h0);
      chk("rst_m_rdata",  bus.m_rdata,      32'h0);
      chk("rst_err_addr", bus.err_addr,     32'h0);
      chk("rst_s_addr",   bus.s_addr,       32'h0);
      chk("rst_s_wdata",  bus.s_wdata,      32'h0);
      chk("rst_s_wstrb",  32'(bus.s_wstrb), 32'h0);
      reset = 1'b0;
      step();

      // Read 0x10: slave 0 disabled, slave 1 (mask FFFF_FC00) is the lowest hit.
      request(32'h0000_0010, 32'h0, 4'b0000);
      step();
      chk("rd_s_sel",       32'(bus.s_sel),   32'h2);
      chk("rd_s_addr",      bus.s_addr,       32'h0000_0010);
      chk("rd_m_ready_n1",  32'(bus.m_ready), 32'h0);
      bus.m_valid = 1'b0;
      bus.s_ready = 4'b0010;
      bus.s_rdata[32 +: 32] = 32'h1234_5678;
      step();
      chk("rd_m_ready_n2",  32'(bus.m_ready), 32'h1);
      chk("rd_m_rdata",     bus.m_rdata,      32'h1234_5678);
      chk("rd_err_irq",     32'(bus.err_irq), 32'h0);
      chk("rd_s_sel_resp",  32'(bus.s_sel),   32'h0);
      bus.s_ready = '0;
      step();
      chk("rd_m_ready_off", 32'(bus.m_ready), 32'h0);

      // Write to slave 3 with five wait cycles before ready.
      bus.s_rdata[96 +: 32] = 32'hDEAD_BEEF;
      request(32'h0010_0004, 32'hAABB_CCDD, 4'b0011);
      step();
      bus.m_valid = 1'b0;
      cnt = 0;
      for (int k = 1; k <= 6; k++) begin
         if (bus.s_sel === 4'b1000 && bus.s_wstrb === 4'b0011) cnt++;
         chk("wr_m_ready_wait", 32'(bus.m_ready), 32'h0);
         if (k == 6) bus.s_ready = 4'b1000;
         step();
      end
      chk("wr_strb_cycles", 32'(cnt),         32'd6);
      chk("wr_s_wdata",     bus.s_wdata,      32'hAABB_CCDD);
      chk("wr_m_ready",     32'(bus.m_ready), 32'h1);
      chk("wr_s_sel_resp",  32'(bus.s_sel),   32'h0);
      bus.s_ready = '0;
      step();
      chk("wr_single_pulse", 32'(bus.m_ready), 32'h0);

      // Unmapped read answers one cycle after request with an error.
      request(32'h8000_0000, 32'h0, 4'b0000);
      step();
      bus.m_valid = 1'b0;
      chk("miss_m_ready",  32'(bus.m_ready), 32'h1);
      chk("miss_err_irq",  32'(bus.err_irq), 32'h1);
      chk("miss_m_rdata",  bus.m_rdata,      32'h0);
      chk("miss_err_addr", bus.err_addr,     32'h8000_0000);
      chk("miss_s_sel",    32'(bus.s_sel),   32'h0);
      step();
      chk("miss_irq_off",  32'(bus.err_irq), 32'h0);
      chk("miss_rdy_off",  32'(bus.m_ready), 32'h0);

      // m_valid held high on misses: ready pulses must be separated by an idle cycle.
      request(32'hC000_0100, 32'h0, 4'b0000);
      step();
      chk("b2b_ready_1",   32'(bus.m_ready), 32'h1);
      step();
      chk("b2b_ready_gap", 32'(bus.m_ready), 32'h0);
      step();
      chk("b2b_ready_2",   32'(bus.m_ready), 32'h1);
      chk("b2b_err_addr",  bus.err_addr,     32'hC000_0100);
      bus.m_valid = 1'b0;
      step();

      // Slave 2 access ignores ready from unselected slaves.
      request(32'h0001_2340, 32'h0, 4'b0000);
      step();
      bus.m_valid = 1'b0;
      chk("s2_s_sel",       32'(bus.s_sel),   32'h4);
      bus.s_ready = 4'b1010;
      step();
      chk("s2_ignore_rdy",  32'(bus.m_ready), 32'h0);
      chk("s2_still_sel",   32'(bus.s_sel),   32'h4);
      bus.s_ready = 4'b0100;
      bus.s_rdata[64 +: 32] = 32'hCAFE_0002;
      step();
      chk("s2_m_ready",     32'(bus.m_ready), 32'h1);
      chk("s2_m_rdata",     bus.m_rdata,      32'hCAFE_0002);
      bus.s_ready = '0;
      step();

      // Reset in the middle of an access.
      request(32'h0010_000C, 32'h5555_AAAA, 4'b1111);
      step();
      bus.m_valid = 1'b0;
      chk("mid_s_sel_pre",  32'(bus.s_sel),   32'h8);
      reset = 1'b1;
      #1;
      chk("mid_s_sel",      32'(bus.s_sel),   32'h0);
      chk("mid_m_ready",    32'(bus.m_ready), 32'h0);
      chk("mid_s_addr",     bus.s_addr,       32'h0);
      chk("mid_s_wstrb",    32'(bus.s_wstrb), 32'h0);
      step();
      reset = 1'b0;
      step();
      request(32'h0000_0200, 32'h0, 4'b0000);
      step();
      bus.m_valid = 1'b0;
      chk("post_s_sel",     32'(bus.s_sel),   32'h2);
      bus.s_ready = 4'b0010;
      bus.s_rdata[32 +: 32] = 32'h0BAD_F00D;
      step();
      chk("post_m_ready",   32'(bus.m_ready), 32'h1);
      chk("post_m_rdata",   bus.m_rdata,      32'h0BAD_F00D);
      bus.s_ready = '0;
      step();

      // Slave 3 never answers.
      request(32'h0010_0008, 32'h0, 4'b0000);
      step();
      bus.m_valid = 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt = 0;
      for (int k = 0; k < 40 && bus.m_ready !== 1'b1; k++) begin
         if (bus.s_sel === 4'b1000) cnt++;
         step();
      end
      chk("tmo_m_ready",    32'(bus.m_ready), 32'h1);
      chk("tmo_cycles",     32'(cnt),         32'd8);
      chk("tmo_err_irq",    32'(bus.err_irq), 32'h1);
      chk("tmo_err_addr",   bus.err_addr,     32'h0010_0008);
      chk("tmo_m_rdata",    bus.m_rdata,      32'h0);
      step();
`else
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bus.m_ready === 1'b1) seen = 1'b1;
         step();
      end
      chk("wait_no_ready",  32'(seen),        32'h0);
      chk("wait_s_sel",     32'(bus.s_sel),   32'h8);
      bus.s_ready = 4'b1000;
      bus.s_rdata[96 +: 32] = 32'h3333_4444;
      step();
      chk("wait_m_ready",   32'(bus.m_ready), 32'h1);
      chk("wait_m_rdata",   bus.m_rdata,      32'h3333_4444);
      chk("wait_err_irq",   32'(bus.err_irq), 32'h0);
      bus.s_ready = '0;
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
